link_master_arbiter: RTL and testbench
======================================

Name: link_master_arbiter

Overview:
Master-side controller for the 4-phase req/ack byte link. It shares the link among NUM_CLIENTS requesters and grants one client at a time for a fixed burst of BURST_LEN bytes, with round-robin fairness between bursts. It drives req/data toward the link slave and sequences the full req-up / ack-up / req-down / ack-down cycle for every byte.

Parameters:
NUM_CLIENTS, 4, number of requesting clients (2..8)
BURST_LEN, 4, bytes per granted burst (1..16)
DATA_W, 8, link data width
TIMEOUT_CYCLES, 64, ack watchdog limit; used only with LINK_TIMEOUT_EN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cli_valid  in  NUM_CLIENTS  client i has a byte available
cli_data  in  NUM_CLIENTS*DATA_W  client i byte at bits [i*DATA_W +: DATA_W]
cli_ready  out  NUM_CLIENTS  byte from client i accepted this cycle (valid&ready)
cli_grant  out  NUM_CLIENTS  one-hot owner of the current burst; 0 when idle
burst_done  out  1  one-cycle pulse after the last byte of a burst completes
busy  out  1  high in any state except IDLE
req  out  1  link request
data  out  DATA_W  link data
ack  in  1  link acknowledge from slave
err  out  1  one-cycle pulse on burst abort (tied 0 without LINK_TIMEOUT_EN)

Behaviour:
- Reset (async, rst_n low): state IDLE. req=0, data=0, cli_grant=0, cli_ready=0, busy=0, burst_done=0, err=0, byte_cnt=0, last_grant=NUM_CLIENTS-1 so client 0 has first priority. req drops immediately, including mid-handshake.
- req, data, cli_grant, busy, burst_done and err are registered or decoded from registered state only. cli_ready is combinational: cli_ready[i] = (state==LOAD) & cli_grant[i] & cli_valid[i].
- FSM states:
  - IDLE: if any cli_valid is set, pick the first set bit searching from last_grant+1 upward with wrap-around. Register one-hot cli_grant and clear byte_cnt, then go to LOAD. If none is set, stay in IDLE.
  - LOAD: if cli_valid[granted] is set, capture its byte into data, pulse cli_ready, then go to REQ. Otherwise stay in LOAD with req=0; the burst is stalled but the grant is held and there is no timeout.
  - REQ: req=1. When ack is sampled as 1, go to WAIT_LOW.
  - WAIT_LOW: req=0. When ack is sampled as 0:
    - if byte_cnt==BURST_LEN-1, pulse burst_done, set last_grant=granted index, clear cli_grant, go to IDLE;
    - otherwise increment byte_cnt and go to LOAD.
- data is held stable from entry to REQ until the next capture in LOAD. The slave may sample data any cycle ack is high.
- Latency: cli_valid rising in IDLE gives req high 2 cycles later (IDLE->LOAD, LOAD->REQ). Minimum per byte is LOAD + REQ + WAIT_LOW, i.e. 3 cycles plus the slave's ack latency.
- A burst is never preempted. Requests from other clients are evaluated only in IDLE.
- If ack is already high on entry to REQ, that is legal: go to WAIT_LOW next cycle. If ack stays high in WAIT_LOW, stay there.
- A client deasserting cli_valid between bursts loses nothing; its next request is arbitrated normally.
- With NUM_CLIENTS=1, the block degrades to a plain sequencer.

Optional Feature:
LINK_TIMEOUT_EN
- Defined: a counter clears on entry to REQ and increments each cycle in REQ. If it reaches TIMEOUT_CYCLES with ack still 0, the block:
  - drops req and pulses err;
  - does not pulse burst_done;
  - sets last_grant=granted index and goes to WAIT_LOW with byte_cnt forced to BURST_LEN-1, so the burst ends cleanly once ack is low.
  Bytes already accepted through cli_ready are lost.
- Not defined: no counter is built, err is constant 0, and REQ waits indefinitely.

Test Plan:
1. Client 0 only, valid held high, bytes A0,A1,A2,A3; slave acks 1 cycle after req and holds ack 2 cycles -> four req pulses carrying A0..A3 in order, 4 cli_ready[0] pulses, then one burst_done, then IDLE with cli_grant=0.
2. Clients 0 and 2 both valid from reset -> burst order 0,2,0,2; cli_grant sequence 0001,0100,0001,0100; never two grants at once.
3. Client 1 drops cli_valid for 5 cycles after byte 2 -> stays in LOAD with req=0 and cli_grant=0010; resumes with byte 3; still exactly 4 bytes and one burst_done.
4. rst_n pulsed low while req=1 in byte 2 -> req, busy and cli_grant go to 0 immediately, without a clock edge; after release, client 0 wins first.
5. LINK_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack tied 0 -> req high exactly 8 cycles, err pulses once, no burst_done, then IDLE; next arbitration starts after the timed-out client.
6. Ack already high when REQ is entered -> one-cycle req, waits in WAIT_LOW until ack falls, data unchanged throughout.

Source files
------------

// File: rtl/link_master_arbiter.sv
// link_master_arbiter: master side of the 4-phase req/ack byte link.
// Shares the link among NUM_CLIENTS requesters, granting one client at a
// time for a fixed burst of BURST_LEN bytes with round-robin fairness.
// Optional feature macro: LINK_TIMEOUT_EN (ack watchdog that aborts a burst).
module link_master_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int BURST_LEN      = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        cli_valid,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cli_data,
    output logic [NUM_CLIENTS-1:0]        cli_ready,
    output logic [NUM_CLIENTS-1:0]        cli_grant,
    output logic                          burst_done,
    output logic                          busy,
    output logic                          req,
    output logic [DATA_W-1:0]             data,
    input  logic                          ack,
    output logic                          err
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        REQ      = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t                   state_reg, state_next;
    logic [NUM_CLIENTS-1:0]   grant_reg, grant_next;
    logic [IDX_W-1:0]         grant_idx_reg, grant_idx_next;
    logic [IDX_W-1:0]         last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]         byte_cnt_reg, byte_cnt_next;
    logic [DATA_W-1:0]        data_reg, data_next;
    logic                     burst_done_reg, burst_done_next;
    logic                     err_reg, err_next;

    logic                     pick_found;
    logic [IDX_W-1:0]         pick_idx;
    int                       cand;
    logic                     sel_valid;
    logic [DATA_W-1:0]        sel_data;
    logic [DATA_W-1:0]        data_terms [NUM_CLIENTS];

    logic                     tmo_hit;
    logic                     aborted;

    // Per-client ready strobe and grant-masked data terms for the byte mux.
    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
            assign cli_ready[gi]  = (state_reg == LOAD) & grant_reg[gi] & cli_valid[gi];
            assign data_terms[gi] = grant_reg[gi] ? cli_data[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    // Select the granted client's valid and byte (grant is one-hot or zero).
    always_comb begin
        sel_valid = |(cli_valid & grant_reg);
        sel_data  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            sel_data = sel_data | data_terms[i];
        end
    end

    // Round-robin pick: first valid client searching upward from last_grant+1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            cand = (int'(last_grant_reg) + k) % NUM_CLIENTS;
            if (!pick_found && cli_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

`ifdef LINK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_reg;
    logic          aborted_reg;

    assign tmo_hit = (state_reg == REQ) && (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
    assign aborted = aborted_reg;

    // Watchdog: zero outside REQ so it is clear on entry, counts while in REQ;
    // remembers an abort so the closing WAIT_LOW does not report burst_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_reg <= '0;
            aborted_reg <= 1'b0;
        end else begin
            tmo_cnt_reg <= (state_reg == REQ) ? tmo_cnt_reg + 1'b1 : '0;
            if (tmo_hit && !ack) begin
                aborted_reg <= 1'b1;
            end else if (state_reg == IDLE) begin
                aborted_reg <= 1'b0;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign aborted = 1'b0;
`endif

    // Next-state and datapath decisions; every register holds unless changed.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        grant_idx_next  = grant_idx_reg;
        last_grant_next = last_grant_reg;
        byte_cnt_next   = byte_cnt_reg;
        data_next       = data_reg;
        burst_done_next = 1'b0;
        err_next        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next     = NUM_CLIENTS'(1) << pick_idx;
                    grant_idx_next = pick_idx;
                    byte_cnt_next  = '0;
                    state_next     = LOAD;
                end
            end
            LOAD: begin
                // Stall with the grant held until the owner offers a byte.
                if (sel_valid) begin
                    data_next  = sel_data;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    state_next = WAIT_LOW;
                end else if (tmo_hit) begin
                    // Abort: finish through WAIT_LOW as if this were the last byte.
                    err_next        = 1'b1;
                    last_grant_next = grant_idx_reg;
                    byte_cnt_next   = LAST_BYTE;
                    state_next      = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!ack) begin
                    if (byte_cnt_reg == LAST_BYTE) begin
                        burst_done_next = !aborted;
                        last_grant_next = grant_idx_reg;
                        grant_next      = '0;
                        state_next      = IDLE;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                        state_next    = LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset drops req immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            grant_idx_reg  <= '0;
            last_grant_reg <= IDX_W'(NUM_CLIENTS - 1);
            byte_cnt_reg   <= '0;
            data_reg       <= '0;
            burst_done_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            grant_idx_reg  <= grant_idx_next;
            last_grant_reg <= last_grant_next;
            byte_cnt_reg   <= byte_cnt_next;
            data_reg       <= data_next;
            burst_done_reg <= burst_done_next;
            err_reg        <= err_next;
        end
    end

    assign req        = (state_reg == REQ);
    assign busy       = (state_reg != IDLE);
    assign cli_grant  = grant_reg;
    assign data       = data_reg;
    assign burst_done = burst_done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_link_master_arbiter.sv
// Testbench for link_master_arbiter: directed scenarios with a scoreboard of
// expected (grant, byte) pairs checked by a monitor on every req rising edge.
module tb_link_master_arbiter;

    localparam int N  = 4;
    localparam int BL = 4;
    localparam int DW = 8;
`ifdef LINK_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      cli_valid;
    logic [N*DW-1:0]   cli_data;
    logic [N-1:0]      cli_ready;
    logic [N-1:0]      cli_grant;
    logic              burst_done;
    logic              busy;
    logic              req;
    logic [DW-1:0]     data;
    wire               ack;
    logic              err;

    logic              mode;      // 0: automatic slave, 1: bench drives man_ack
    logic              man_ack;
    logic              auto_ack;
    assign ack = mode ? man_ack : auto_ack;

    link_master_arbiter #(
        .NUM_CLIENTS(N), .BURST_LEN(BL), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cli_valid(cli_valid), .cli_data(cli_data),
        .cli_ready(cli_ready), .cli_grant(cli_grant), .burst_done(burst_done),
        .busy(busy), .req(req), .data(data), .ack(ack), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  g;
        logic [DW-1:0] d;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int bd_count = 0;
    int err_count = 0;

    int idx   [N] = '{default: 0};   // bytes accepted per client
    int limit [N] = '{default: 0};   // total bytes a client may offer
    bit en    [N] = '{default: 0};

    function automatic logic [DW-1:0] byte_of(input int c, input int k);
        return DW'(8'hA0 + c * 16 + k);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic push_burst(input int c, input int first);
        for (int k = 0; k < BL; k++) begin
            exp_q.push_back('{g: N'(1) << c, d: byte_of(c, first + k)});
        end
    endtask

    task automatic wait_bursts(input string name, input int target);
        int n;
        n = 0;
        while (bd_count < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, bd_count, target);
        chk({name, "_q_empty"}, exp_q.size(), 0);
    endtask

    // Client byte sources: advance after each accepted byte, update after the edge.
    initial begin
        logic [N-1:0] rdy_s;
        cli_valid = '0;
        cli_data  = '0;
        forever begin
            @(negedge clk);
            rdy_s = cli_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rdy_s[i]) idx[i]++;
                cli_valid[i] = en[i] && (idx[i] < limit[i]);
                cli_data[i*DW +: DW] = byte_of(i, idx[i]);
            end
        end
    end

    // Link slave: ack 1 cycle after req, held for 2 cycles.
    initial begin
        auto_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!mode && rst_n && req && !auto_ack) begin
                @(posedge clk);
                #1 auto_ack = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1 auto_ack = 1'b0;
            end
        end
    end

    // Monitor: every link transfer (req rising) must match the scoreboard head.
    initial begin
        logic req_prev;
        exp_t e;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (!$onehot0(cli_grant)) begin
                    failures++;
                    $display("FAIL grant_onehot: got %b expected at most one bit", cli_grant);
                end
                if (req && !req_prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL xfer_unexpected: got grant=%b data=%h expected no transfer", cli_grant, data);
                    end else begin
                        e = exp_q.pop_front();
                        if (cli_grant !== e.g || data !== e.d) begin
                            failures++;
                            $display("FAIL xfer: got grant=%b data=%h expected grant=%b data=%h",
                                     cli_grant, data, e.g, e.d);
                        end else begin
                            $display("xfer grant=%b data=%h", cli_grant, data);
                        end
                    end
                end
                if (burst_done) bd_count++;
                if (err) err_count++;
            end
            req_prev = req;
        end
    end

    initial begin
        int n;
        int bd0;
        int e0;
        rst_n   = 1'b0;
        mode    = 1'b0;
        man_ack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", cli_grant, 0);
        chk("rst_data", data, 0);
        chk("rst_burst_done", burst_done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", cli_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: client 0 alone, bytes A0..A3, latency to req is 2 cycles
        limit[0] = 4;
        push_burst(0, 0);
        en[0] = 1;
        @(posedge clk);
        @(negedge clk);
        chk("t1_idle_grant", cli_grant, 0);
        @(negedge clk);
        chk("t1_load_grant", cli_grant, 4'b0001);
        chk("t1_load_req", req, 0);
        chk("t1_load_ready", cli_ready, 4'b0001);
        @(negedge clk);
        chk("t1_req_high", req, 1);
        wait_bursts("t1_bursts", 1);
        @(negedge clk);
        chk("t1_end_grant", cli_grant, 0);
        chk("t1_end_busy", busy, 0);
        chk("t1_accepted", idx[0], 4);
        en[0] = 0;

        // 2: clients 0 and 2 from reset -> bursts 0,2,0,2
        rst_n = 1'b0;
        limit[0] = idx[0] + 8;
        limit[2] = idx[2] + 8;
        push_burst(0, idx[0]);
        push_burst(2, idx[2]);
        push_burst(0, idx[0] + 4);
        push_burst(2, idx[2] + 4);
        en[0] = 1;
        en[2] = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_bursts("t2_bursts", 5);
        chk("t2_acc0", idx[0], 12);
        chk("t2_acc2", idx[2], 8);
        en[0] = 0;
        en[2] = 0;

        // 3: client 1 stalls after its second byte; burst holds in LOAD
        limit[1] = 4;
        push_burst(1, 0);
        en[1] = 1;
        n = 0;
        while (idx[1] < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t3_reach_byte2", idx[1], 2);
        en[1] = 0;
        repeat (8) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk("t3_stall_req", req, 0);
            chk("t3_stall_grant", cli_grant, 4'b0010);
            @(negedge clk);
        end
        en[1] = 1;
        wait_bursts("t3_bursts", 6);
        chk("t3_accepted", idx[1], 4);
        en[1] = 0;

        // 4: asynchronous reset while req is high in byte 2
        limit[0] = idx[0] + 4;
        push_burst(0, idx[0]);
        en[0] = 1;
        n = 0;
        while (!(idx[0] == 14 && req) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_req_before", req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_req", req, 0);
        chk("t4_async_busy", busy, 0);
        chk("t4_async_grant", cli_grant, 0);
        exp_q.delete();
        en[0] = 0;
        repeat (4) @(negedge clk);
        n = 0;
        while (auto_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        limit[0] = idx[0] + 4;
        limit[2] = idx[2] + 4;
        push_burst(0, idx[0]);
        push_burst(2, idx[2]);
        en[0] = 1;
        en[2] = 1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_bursts("t4_bursts", 8);
        en[0] = 0;
        en[2] = 0;

        // 6: ack already high when REQ is entered
        limit[3] = 4;
        push_burst(3, 0);
        mode = 1'b1;
        man_ack = 1'b1;
        en[3] = 1;
        n = 0;
        while (!req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_req_seen", req, 1);
        chk("t6_data", data, 8'hD0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t6_wait_req", req, 0);
            chk("t6_wait_data", data, 8'hD0);
            chk("t6_wait_busy", busy, 1);
        end
        man_ack = 1'b0;
        mode = 1'b0;
        wait_bursts("t6_bursts", 9);
        en[3] = 0;

`ifdef LINK_TIMEOUT_EN
        // 5: ack never arrives -> req for TMO cycles, err pulse, no burst_done
        bd0 = bd_count;
        e0  = err_count;
        mode = 1'b1;
        man_ack = 1'b0;
        limit[1] = idx[1] + 1;
        exp_q.push_back('{g: 4'b0010, d: byte_of(1, idx[1])});
        en[1] = 1;
        n = 0;
        while (!req && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (req && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("t5_req_cycles", n, TMO);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_idle", busy, 0);
        chk("t5_err_pulses", err_count, e0 + 1);
        chk("t5_no_done", bd_count, bd0);
        en[1] = 0;
        mode = 1'b0;
        limit[0] = idx[0] + 4;
        limit[2] = idx[2] + 4;
        push_burst(2, idx[2]);
        push_burst(0, idx[0]);
        en[0] = 1;
        en[2] = 1;
        wait_bursts("t5_next_bursts", bd0 + 2);
        en[0] = 0;
        en[2] = 0;
`else
        bd0 = bd_count;
        e0  = err_count;
        chk("no_err_default", e0, 0);
        chk("done_total", bd0, 9);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
